// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bus: controller/regfile fields in (D), pipelined fields out (E),
// plus hazard controls and debug event counters.
interface id_ex_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic            ValidD, RegWriteD, MemWriteD, BranchD, JumpD;
  logic [1:0]      ResultSrcD;
  logic [3:0]      ALUControlD;
  logic            ALUSrcASelD, ALUSrcBSelD;
  logic [XLEN-1:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
  logic [4:0]      Rs1D, Rs2D, RdD;
  logic            PCSrcE;

  logic            ValidE, RegWriteE, MemWriteE, BranchE, JumpE;
  logic [1:0]      ResultSrcE;
  logic [3:0]      ALUControlE;
  logic            ALUSrcASelE, ALUSrcBSelE;
  logic [XLEN-1:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]      Rs1E, Rs2E, RdE;

  logic             StallF, StallD, FlushD;
  logic [CNT_W-1:0] StallCount, FlushCount;

  modport master (
    output ValidD, RegWriteD, MemWriteD, BranchD, JumpD, ResultSrcD, ALUControlD,
           ALUSrcASelD, ALUSrcBSelD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D,
           Rs1D, Rs2D, RdD, PCSrcE,
    input  ValidE, RegWriteE, MemWriteE, BranchE, JumpE, ResultSrcE, ALUControlE,
           ALUSrcASelE, ALUSrcBSelE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
           Rs1E, Rs2E, RdE, StallF, StallD, FlushD, StallCount, FlushCount
  );

  modport slave (
    input  ValidD, RegWriteD, MemWriteD, BranchD, JumpD, ResultSrcD, ALUControlD,
           ALUSrcASelD, ALUSrcBSelD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D,
           Rs1D, Rs2D, RdD, PCSrcE,
    output ValidE, RegWriteE, MemWriteE, BranchE, JumpE, ResultSrcE, ALUControlE,
           ALUSrcASelE, ALUSrcBSelE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
           Rs1E, Rs2E, RdE, StallF, StallD, FlushD, StallCount, FlushCount
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use interlock, redirect flush and
// saturating stall/flush event counters.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          reset,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic            valid;
    logic            regWrite;
    logic            memWrite;
    logic [1:0]      resultSrc;
    logic            branch;
    logic            jump;
    logic [3:0]      aluControl;
    logic            aluSrcASel;
    logic            aluSrcBSel;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] immExt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcPlus4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } stage_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  stage_t           stage_q, stage_d, decodeFields;
  logic             loadUse, bubbleE, stallEvent;
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d, flushCnt_q, flushCnt_d;

  // Rs fields are compared even when the format does not read them; a spurious
  // stall costs one cycle, a missed one corrupts data.
  always_comb begin
    loadUse = stage_q.valid & bus.ValidD & (stage_q.resultSrc == 2'b01) &
              (stage_q.rd != 5'd0) &
              ((bus.Rs1D == stage_q.rd) | (bus.Rs2D == stage_q.rd));
    stallEvent = loadUse & ~bus.PCSrcE;
    bubbleE    = loadUse | bus.PCSrcE;
  end

  always_comb begin
    decodeFields.valid      = bus.ValidD;
    decodeFields.regWrite   = bus.RegWriteD;
    decodeFields.memWrite   = bus.MemWriteD;
    decodeFields.resultSrc  = bus.ResultSrcD;
    decodeFields.branch     = bus.BranchD;
    decodeFields.jump       = bus.JumpD;
    decodeFields.aluControl = bus.ALUControlD;
    decodeFields.aluSrcASel = bus.ALUSrcASelD;
    decodeFields.aluSrcBSel = bus.ALUSrcBSelD;
    decodeFields.rd1        = bus.RD1D;
    decodeFields.rd2        = bus.RD2D;
    decodeFields.immExt     = bus.ImmExtD;
    decodeFields.pc         = bus.PCD;
    decodeFields.pcPlus4    = bus.PCPlus4D;
    decodeFields.rs1        = bus.Rs1D;
    decodeFields.rs2        = bus.Rs2D;
    decodeFields.rd         = bus.RdD;
  end

  // An all-zero bubble leaves RdE=0 so the next cycle's hazard compare stays quiet.
  always_comb begin
    stage_d = (bubbleE | ~bus.ValidD) ? '0 : decodeFields;

    stallCnt_d = stallCnt_q;
    if (stallEvent && (stallCnt_q != CNT_MAX)) stallCnt_d = stallCnt_q + CNT_W'(1);

    flushCnt_d = flushCnt_q;
    if (bus.PCSrcE && (flushCnt_q != CNT_MAX)) flushCnt_d = flushCnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q    <= '0;
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      stage_q    <= stage_d;
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  assign bus.StallF     = stallEvent;
  assign bus.StallD     = stallEvent;
  assign bus.FlushD     = bus.PCSrcE;
  assign bus.StallCount = stallCnt_q;
  assign bus.FlushCount = flushCnt_q;

  assign bus.ValidE      = stage_q.valid;
  assign bus.RegWriteE   = stage_q.regWrite;
  assign bus.MemWriteE   = stage_q.memWrite;
  assign bus.ResultSrcE  = stage_q.resultSrc;
  assign bus.BranchE     = stage_q.branch;
  assign bus.JumpE       = stage_q.jump;
  assign bus.ALUControlE = stage_q.aluControl;
  assign bus.ALUSrcASelE = stage_q.aluSrcASel;
  assign bus.ALUSrcBSelE = stage_q.aluSrcBSel;
  assign bus.RD1E        = stage_q.rd1;
  assign bus.RD2E        = stage_q.rd2;
  assign bus.ImmExtE     = stage_q.immExt;
  assign bus.PCE         = stage_q.pc;
  assign bus.PCPlus4E    = stage_q.pcPlus4;
  assign bus.Rs1E        = stage_q.rs1;
  assign bus.Rs2E        = stage_q.rs2;
  assign bus.RdE         = stage_q.rd;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios then random traffic, all compared
// against an instruction-level reference model of the ID/EX slot.
module tb_id_ex_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 2;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  id_ex_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the instruction occupying the execute slot, as a record.
  typedef struct {
    bit              valid, regWrite, memWrite, branch, jump, srcA, srcB;
    bit [1:0]        resultSrc;
    bit [3:0]        aluCtl;
    bit [XLEN-1:0]   rd1, rd2, imm, pc, pcPlus4;
    bit [4:0]        rs1, rs2, rd;
  } instr_t;

  instr_t modelE;
  int     modelStalls;
  int     modelFlushes;
  int     countMax;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic clearInputs();
    bus.ValidD = 0; bus.RegWriteD = 0; bus.MemWriteD = 0; bus.ResultSrcD = 2'b00;
    bus.BranchD = 0; bus.JumpD = 0; bus.ALUControlD = 4'h0;
    bus.ALUSrcASelD = 0; bus.ALUSrcBSelD = 0;
    bus.RD1D = '0; bus.RD2D = '0; bus.ImmExtD = '0; bus.PCD = '0; bus.PCPlus4D = '0;
    bus.Rs1D = '0; bus.Rs2D = '0; bus.RdD = '0; bus.PCSrcE = 0;
  endtask

  task automatic applyStimulus();
    bus.ValidD      = ($urandom_range(0, 7) != 0);
    bus.RegWriteD   = 1'($urandom);
    bus.MemWriteD   = 1'($urandom);
    bus.ResultSrcD  = 2'($urandom_range(0, 2));
    bus.BranchD     = 1'($urandom);
    bus.JumpD       = 1'($urandom);
    bus.ALUControlD = 4'($urandom);
    bus.ALUSrcASelD = 1'($urandom);
    bus.ALUSrcBSelD = 1'($urandom);
    bus.RD1D        = $urandom;
    bus.RD2D        = $urandom;
    bus.ImmExtD     = $urandom;
    bus.PCD         = $urandom & 32'hFFFF_FFFC;
    bus.PCPlus4D    = bus.PCD + 32'd4;
    bus.Rs1D        = ($urandom_range(0, 2) == 0) ? modelE.rd : 5'($urandom_range(0, 7));
    bus.Rs2D        = ($urandom_range(0, 3) == 0) ? modelE.rd : 5'($urandom_range(0, 7));
    bus.RdD         = 5'($urandom_range(0, 7));
    bus.PCSrcE      = ($urandom_range(0, 5) == 0);
    reset           = ($urandom_range(0, 40) == 0);
  endtask

  task automatic checkE();
    checkOutput("ValidE",      bus.ValidE,      modelE.valid);
    checkOutput("RegWriteE",   bus.RegWriteE,   modelE.regWrite);
    checkOutput("MemWriteE",   bus.MemWriteE,   modelE.memWrite);
    checkOutput("ResultSrcE",  bus.ResultSrcE,  modelE.resultSrc);
    checkOutput("BranchE",     bus.BranchE,     modelE.branch);
    checkOutput("JumpE",       bus.JumpE,       modelE.jump);
    checkOutput("ALUControlE", bus.ALUControlE, modelE.aluCtl);
    checkOutput("ALUSrcASelE", bus.ALUSrcASelE, modelE.srcA);
    checkOutput("ALUSrcBSelE", bus.ALUSrcBSelE, modelE.srcB);
    checkOutput("RD1E",        bus.RD1E,        modelE.rd1);
    checkOutput("RD2E",        bus.RD2E,        modelE.rd2);
    checkOutput("ImmExtE",     bus.ImmExtE,     modelE.imm);
    checkOutput("PCE",         bus.PCE,         modelE.pc);
    checkOutput("PCPlus4E",    bus.PCPlus4E,    modelE.pcPlus4);
    checkOutput("Rs1E",        bus.Rs1E,        modelE.rs1);
    checkOutput("Rs2E",        bus.Rs2E,        modelE.rs2);
    checkOutput("RdE",         bus.RdE,         modelE.rd);
    checkOutput("StallCount",  bus.StallCount,  modelStalls);
    checkOutput("FlushCount",  bus.FlushCount,  modelFlushes);
  endtask

  // One cycle: check hazard outputs against the model, clock, then check E state.
  task automatic advanceClock();
    instr_t fresh;
    bit     dependsOnLoad, hazard, redirect;
    #1;
    dependsOnLoad = modelE.valid && bus.ValidD && modelE.resultSrc == 2'b01 &&
                    modelE.rd != 0 && (bus.Rs1D == modelE.rd || bus.Rs2D == modelE.rd);
    redirect = bus.PCSrcE;
    hazard   = dependsOnLoad && !redirect;
    checkOutput("StallF", bus.StallF, hazard);
    checkOutput("StallD", bus.StallD, hazard);
    checkOutput("FlushD", bus.FlushD, redirect);

    fresh = '{default: '0};
    if (reset) begin
      modelE       = fresh;
      modelStalls  = 0;
      modelFlushes = 0;
    end else begin
      if (hazard)   modelStalls  = (modelStalls  < countMax) ? modelStalls  + 1 : countMax;
      if (redirect) modelFlushes = (modelFlushes < countMax) ? modelFlushes + 1 : countMax;
      if (!dependsOnLoad && !redirect && bus.ValidD) begin
        fresh.valid = 1; fresh.regWrite = bus.RegWriteD; fresh.memWrite = bus.MemWriteD;
        fresh.resultSrc = bus.ResultSrcD; fresh.branch = bus.BranchD; fresh.jump = bus.JumpD;
        fresh.aluCtl = bus.ALUControlD; fresh.srcA = bus.ALUSrcASelD; fresh.srcB = bus.ALUSrcBSelD;
        fresh.rd1 = bus.RD1D; fresh.rd2 = bus.RD2D; fresh.imm = bus.ImmExtD;
        fresh.pc = bus.PCD; fresh.pcPlus4 = bus.PCPlus4D;
        fresh.rs1 = bus.Rs1D; fresh.rs2 = bus.Rs2D; fresh.rd = bus.RdD;
      end
      modelE = fresh;
    end

    @(posedge clk);
    #1;
    checkE();
  endtask

  task automatic loadWord(input logic [4:0] rd);
    clearInputs();
    bus.ValidD = 1; bus.RegWriteD = 1; bus.ResultSrcD = 2'b01;
    bus.ALUSrcBSelD = 1; bus.RdD = rd; bus.Rs1D = 5'd2;
    advanceClock();
  endtask

  task automatic doReset();
    clearInputs();
    reset = 1;
    advanceClock();
    reset = 0;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    countMax     = (1 << CNT_W) - 1;
    modelE       = '{default: '0};
    modelStalls  = 0;
    modelFlushes = 0;
    reset        = 1;
    clearInputs();

    // Scenario 1: reset then ADD pass-through.
    doReset();
    checkOutput("rstValidE", bus.ValidE, 0);
    checkOutput("rstStallCount", bus.StallCount, 0);
    bus.ValidD = 1; bus.RegWriteD = 1; bus.ALUControlD = 4'b0000; bus.ResultSrcD = 2'b00;
    bus.RdD = 5'd7; bus.RD1D = 32'h11; bus.RD2D = 32'h22; bus.Rs1D = 5'd1; bus.Rs2D = 5'd3;
    #1;
    checkOutput("addStallF", bus.StallF, 0);
    checkOutput("addFlushD", bus.FlushD, 0);
    advanceClock();
    checkOutput("addRegWriteE", bus.RegWriteE, 1);
    checkOutput("addRdE", bus.RdE, 7);
    checkOutput("addRD1E", bus.RD1E, 32'h11);
    checkOutput("addRD2E", bus.RD2E, 32'h22);
    checkOutput("addValidE", bus.ValidE, 1);

    // Scenario 2: load-use stall of exactly one cycle.
    doReset();
    loadWord(5'd5);
    clearInputs();
    bus.ValidD = 1; bus.RegWriteD = 1; bus.Rs1D = 5'd5; bus.Rs2D = 5'd9; bus.RdD = 5'd6;
    bus.RD1D = 32'hABCD;
    #1;
    checkOutput("luStallF", bus.StallF, 1);
    checkOutput("luStallD", bus.StallD, 1);
    advanceClock();
    checkOutput("luBubbleRegWriteE", bus.RegWriteE, 0);
    checkOutput("luBubbleValidE", bus.ValidE, 0);
    checkOutput("luStallCount", bus.StallCount, 1);
    #1;
    checkOutput("luReleaseStallF", bus.StallF, 0);
    advanceClock();
    checkOutput("luHeldRdE", bus.RdE, 6);
    checkOutput("luHeldValidE", bus.ValidE, 1);

    // Scenario 3: load to x0 never stalls.
    doReset();
    loadWord(5'd0);
    clearInputs();
    bus.ValidD = 1; bus.Rs1D = 5'd0; bus.RdD = 5'd4;
    #1;
    checkOutput("x0StallF", bus.StallF, 0);
    advanceClock();
    checkOutput("x0StallCount", bus.StallCount, 0);
    checkOutput("x0ValidE", bus.ValidE, 1);

    // Scenario 4: redirect squashes the decode instruction.
    doReset();
    clearInputs();
    bus.ValidD = 1; bus.RegWriteD = 1; bus.RdD = 5'd3; bus.PCSrcE = 1;
    #1;
    checkOutput("rdFlushD", bus.FlushD, 1);
    advanceClock();
    checkOutput("rdValidE", bus.ValidE, 0);
    checkOutput("rdFlushCount", bus.FlushCount, 1);

    // Scenario 5: load-use coinciding with redirect; the flush wins.
    doReset();
    loadWord(5'd5);
    clearInputs();
    bus.ValidD = 1; bus.RegWriteD = 1; bus.Rs2D = 5'd5; bus.RdD = 5'd8; bus.PCSrcE = 1;
    #1;
    checkOutput("bothStallF", bus.StallF, 0);
    checkOutput("bothFlushD", bus.FlushD, 1);
    advanceClock();
    checkOutput("bothValidE", bus.ValidE, 0);
    checkOutput("bothFlushCount", bus.FlushCount, 1);
    checkOutput("bothStallCount", bus.StallCount, 0);

    // Scenario 6: flush counter saturation, then reset over a valid store.
    doReset();
    clearInputs();
    bus.ValidD = 1; bus.PCSrcE = 1;
    for (int i = 0; i < 5; i++) advanceClock();
    checkOutput("satFlushCount", bus.FlushCount, 3);
    clearInputs();
    bus.ValidD = 1; bus.MemWriteD = 1; bus.Rs1D = 5'd2; bus.Rs2D = 5'd3;
    advanceClock();
    checkOutput("swMemWriteE", bus.MemWriteE, 1);
    doReset();
    checkOutput("swRstMemWriteE", bus.MemWriteE, 0);
    checkOutput("swRstValidE", bus.ValidE, 0);
    checkOutput("swRstFlushCount", bus.FlushCount, 0);
    checkOutput("swRstStallCount", bus.StallCount, 0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus();
      advanceClock();
    end
    reset = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
